// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter with round-robin contention, abort handling
// and a per-transfer watchdog that terminates stalled slave accesses.
module wishbone_arbiter #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  // master 0
  input  logic                           m0_cyc,
  input  logic                           m0_stb,
  input  logic                           m0_we,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] m0_sel,
  input  logic [ADDR_SIZE-1:0]           m0_addr,
  input  logic [DATA_SIZE-1:0]           m0_dat_w,
  output logic [DATA_SIZE-1:0]           m0_dat_r,
  output logic                           m0_ack,
  output logic                           m0_err,
  // master 1
  input  logic                           m1_cyc,
  input  logic                           m1_stb,
  input  logic                           m1_we,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] m1_sel,
  input  logic [ADDR_SIZE-1:0]           m1_addr,
  input  logic [DATA_SIZE-1:0]           m1_dat_w,
  output logic [DATA_SIZE-1:0]           m1_dat_r,
  output logic                           m1_ack,
  output logic                           m1_err,
  // shared slave port
  output logic                           s_cyc,
  output logic                           s_stb,
  output logic                           s_we,
  output logic [DATA_SIZE/BYTE_SIZE-1:0] s_sel,
  output logic [ADDR_SIZE-1:0]           s_addr,
  output logic [DATA_SIZE-1:0]           s_dat_w,
  input  logic [DATA_SIZE-1:0]           s_dat_r,
  input  logic                           s_ack,
  // one-hot bus owner
  output logic [1:0]                     grant
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam bit          WDT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] wdt_q;

  logic req0;
  logic req1;
  logic own0;
  logic own1;
  logic cur_cyc;
  logic oth_req;
  logic timeout;

  assign req0  = m0_cyc & m0_stb;
  assign req1  = m1_cyc & m1_stb;
  assign grant = {own1, own0};

  // Decode the current owner and detect a watchdog expiry this cycle.
  always_comb begin
    own0    = (state_q == BUS0);
    own1    = (state_q == BUS1);
    cur_cyc = 1'b0;
    oth_req = 1'b0;
    if (own0) begin
      cur_cyc = m0_cyc;
      oth_req = req1;
    end else if (own1) begin
      cur_cyc = m1_cyc;
      oth_req = req0;
    end
    // An ack in the same cycle wins over the timeout; an abort suppresses it.
    timeout = WDT_EN && (own0 || own1) && cur_cyc && !s_ack && (wdt_q == CNT_LIMIT);
  end

  // Arbitration FSM, round-robin history and saturating watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wdt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wdt_q <= '0;
          if (req0 && (!req1 || last_grant_q)) begin
            state_q <= BUS0;
          end else if (req1) begin
            state_q <= BUS1;
          end
        end
        BUS0, BUS1: begin
          if (s_ack) begin
            // Hand over directly only to the other master, never back to self.
            last_grant_q <= own1;
            wdt_q        <= '0;
            if (oth_req) begin
              state_q <= own0 ? BUS1 : BUS0;
            end else begin
              state_q <= IDLE;
            end
          end else if (!cur_cyc) begin
            state_q <= IDLE;
            wdt_q   <= '0;
          end else if (timeout) begin
            last_grant_q <= own1;
            state_q      <= IDLE;
            wdt_q        <= '0;
          end else if (wdt_q != CNT_SAT) begin
            wdt_q <= wdt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          wdt_q   <= '0;
        end
      endcase
    end
  end

  // Route the owner onto the slave port and the slave response back to it.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_addr   = '0;
    s_dat_w  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_r = '0;
    if (!reset) begin
      if (own0) begin
        s_cyc    = m0_cyc & ~timeout;
        s_stb    = req0 & ~timeout;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_dat_w  = m0_dat_w;
        m0_ack   = s_ack;
        m0_err   = timeout;
        m0_dat_r = s_dat_r;
      end else if (own1) begin
        s_cyc    = m1_cyc & ~timeout;
        s_stb    = req1 & ~timeout;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_dat_w  = m1_dat_w;
        m1_ack   = s_ack;
        m1_err   = timeout;
        m1_dat_r = s_dat_r;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: transaction-level ownership model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_wishbone_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int          TO = 8;

  localparam int P_G01   = 0;
  localparam int P_G10   = 1;
  localparam int P_IDLE  = 2;
  localparam int P_M0ACK = 3;
  localparam int P_M1ACK = 4;
  localparam int P_M0ERR = 5;
  localparam int P_M1ERR = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    m_cyc;
  logic [1:0]    m_stb;
  logic [1:0]    m_we = 2'b00;
  logic [SW-1:0] m_sel   [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_dat_w [2];
  logic [DW-1:0] m0_dat_r, m1_dat_r;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [SW-1:0] s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_dat_w;
  logic [DW-1:0] s_dat_r = '0;
  logic          s_ack;
  logic [1:0]    grant;

  int   issued [2] = '{0, 0};
  int   done   [2] = '{0, 0};
  logic [1:0] m_drop = 2'b00;
  int   slave_dly = 4;
  logic force_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // ownership model: -1 idle, else owning master index
  int own  = -1;
  bit last = 1'b1;
  int age  = 0;

  wishbone_arbiter #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .BYTE_SIZE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_sel(m_sel[0]),
    .m0_addr(m_addr[0]), .m0_dat_w(m_dat_w[0]), .m0_dat_r(m0_dat_r),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_sel(m_sel[1]),
    .m1_addr(m_addr[1]), .m1_dat_w(m_dat_w[1]), .m1_dat_r(m1_dat_r),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
    .grant(grant)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      P_G01:   return grant == 2'b01;
      P_G10:   return grant == 2'b10;
      P_IDLE:  return grant == 2'b00;
      P_M0ACK: return m0_ack;
      P_M1ACK: return m1_ack;
      P_M0ERR: return m0_err;
      P_M1ERR: return m1_err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output int waited, output logic ok);
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited <= budget) begin
      if (probe(sel)) ok = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  // Masters: request while transfers are outstanding; ack, err or reset completes them.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        done[0] = issued[0];
        done[1] = issued[1];
      end else begin
        if (m0_ack || m0_err) done[0]++;
        if (m1_ack || m1_err) done[1]++;
      end
    end
  end

  initial begin
    m_cyc = 2'b00;
    m_stb = 2'b00;
    forever begin
      @(posedge clock);
      #1;
      for (int n = 0; n < 2; n++) begin
        m_cyc[n] = (issued[n] != done[n]) && !m_drop[n];
        m_stb[n] = m_cyc[n];
      end
    end
  end

  // Slave: acks slave_dly cycles after the strobe first appears (0 = never), or on force_ack.
  initial begin
    int   scnt;
    logic nxt;
    scnt  = 0;
    nxt   = 1'b0;
    s_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (s_ack || !(s_cyc && s_stb)) scnt = 0;
      else scnt++;
      nxt = (slave_dly != 0) && (scnt == slave_dly);
      @(posedge clock);
      #1;
      s_ack = nxt || force_ack;
    end
  end

  // Model: advance bus ownership by the arbitration rules on each rising edge.
  task automatic model_step();
    logic r0, r1, ro;
    int   n;
    r0 = m_cyc[0] & m_stb[0];
    r1 = m_cyc[1] & m_stb[1];
    if (reset) begin
      own = -1; last = 1'b1; age = 0;
    end else if (own < 0) begin
      if (r0 && r1) own = last ? 0 : 1;
      else if (r0) own = 0;
      else if (r1) own = 1;
      age = 0;
    end else begin
      n  = own;
      ro = (n == 0) ? r1 : r0;
      if (s_ack) begin
        last = (n == 1);
        own  = ro ? 1 - n : -1;
        age  = 0;
      end else if (!m_cyc[n]) begin
        own = -1;
        age = 0;
      end else if ((TO != 0) && (age == TO)) begin
        last = (n == 1);
        own  = -1;
        age  = 0;
      end else begin
        age++;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Compare every DUT output against the model mid-cycle.
  task automatic check_cycle();
    logic live, tmo;
    int   n;
    logic [1:0] eg;
    n    = (own < 0) ? 0 : own;
    live = !reset && (own >= 0);
    tmo  = live && (TO != 0) && (age == TO) && m_cyc[n] && !s_ack;
    eg   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    chk("cmp_grant",   64'(grant),    64'(eg));
    chk("cmp_s_cyc",   64'(s_cyc),    64'(live && m_cyc[n] && !tmo));
    chk("cmp_s_stb",   64'(s_stb),    64'(live && m_cyc[n] && m_stb[n] && !tmo));
    chk("cmp_s_we",    64'(s_we),     64'(live && m_we[n]));
    chk("cmp_s_sel",   64'(s_sel),    64'(live ? m_sel[n] : 4'h0));
    chk("cmp_s_addr",  64'(s_addr),   64'(live ? m_addr[n] : 32'h0));
    chk("cmp_s_dat_w", 64'(s_dat_w),  64'(live ? m_dat_w[n] : 32'h0));
    chk("cmp_m0_ack",  64'(m0_ack),   64'(live && n == 0 && s_ack));
    chk("cmp_m1_ack",  64'(m1_ack),   64'(live && n == 1 && s_ack));
    chk("cmp_m0_err",  64'(m0_err),   64'(tmo && n == 0));
    chk("cmp_m1_err",  64'(m1_err),   64'(tmo && n == 1));
    chk("cmp_m0_dat",  64'(m0_dat_r), 64'((live && n == 0) ? s_dat_r : 32'h0));
    chk("cmp_m1_dat",  64'(m1_dat_r), 64'((live && n == 1) ? s_dat_r : 32'h0));
  endtask

  initial forever begin
    @(negedge clock);
    check_cycle();
  end

  initial begin
    #100000;
    $display("FAIL global_watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  // Directed scenarios.
  initial begin
    int   w;
    logic ok;
    int   acks, m1acks;
    logic bad;

    m_sel[0]   = 4'h3;          m_sel[1]   = 4'hC;
    m_addr[0]  = 32'h0000_1000; m_addr[1]  = 32'h0000_2000;
    m_dat_w[0] = 32'hDEAD_0000; m_dat_w[1] = 32'hBEEF_1111;

    repeat (3) tick();
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_s_cyc", 64'(s_cyc), 64'(0));
    chk("rst_m_ack", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));

    // both masters contend right after reset; m0 first, then direct handover
    s_dat_r   = 32'h1111_2222;
    slave_dly = 4;
    reset     = 1'b0;
    issued[0] = 1;
    issued[1] = 1;
    wait_sig(P_G01, 6, w, ok);
    chk("A_grant_m0_first", 64'(ok), 64'(1));
    wait_sig(P_M0ACK, 8, w, ok);
    chk("A_m0_ack_seen", 64'(ok), 64'(1));
    chk("A_m0_ack_latency", 64'(w), 64'(4));
    chk("A_m0_dat_r", 64'(m0_dat_r), 64'(32'h1111_2222));
    tick();
    chk("A_grant_m1_no_gap", 64'(grant), 64'(2'b10));
    wait_sig(P_M1ACK, 8, w, ok);
    chk("A_m1_ack_latency", 64'(w), 64'(4));
    chk("A_m1_dat_r", 64'(m1_dat_r), 64'(32'h1111_2222));
    wait_sig(P_IDLE, 6, w, ok);
    chk("A_idle", 64'(ok), 64'(1));
    repeat (2) tick();

    // three back-to-back m0 reads, each passing through idle
    s_dat_r   = 32'hA5A5_A5A5;
    slave_dly = 2;
    issued[0] = issued[0] + 3;
    acks      = 0;
    m1acks    = 0;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      tick();
      if (m1_ack) m1acks++;
      if (m0_ack) begin
        acks++;
        chk("B_m0_dat_r", 64'(m0_dat_r), 64'(32'hA5A5_A5A5));
        tick();
        chk("B_idle_after_ack", 64'(grant), 64'(2'b00));
      end
    end
    chk("B_three_acks", 64'(acks), 64'(3));
    chk("B_m1_ack_never", 64'(m1acks), 64'(0));
    repeat (3) tick();

    // m1 write routed to the slave port
    m_addr[1]  = 32'h0100_0000;
    m_sel[1]   = 4'hF;
    m_dat_w[1] = 32'h0;
    m_we[1]    = 1'b1;
    slave_dly  = 4;
    issued[1]  = issued[1] + 1;
    wait_sig(P_G10, 6, w, ok);
    chk("C_grant_m1", 64'(ok), 64'(1));
    chk("C_s_addr", 64'(s_addr), 64'(32'h0100_0000));
    chk("C_s_we", 64'(s_we), 64'(1));
    chk("C_s_sel", 64'(s_sel), 64'(4'hF));
    chk("C_s_dat_w", 64'(s_dat_w), 64'(32'h0));
    wait_sig(P_M1ACK, 8, w, ok);
    chk("C_m1_ack", 64'(ok), 64'(1));
    repeat (3) tick();

    // silent slave: watchdog terminates m0, then m1 is served and also times out
    slave_dly = 0;
    issued[0] = issued[0] + 1;
    tick();
    tick();
    issued[1] = issued[1] + 1;
    wait_sig(P_G01, 6, w, ok);
    chk("D_grant_m0", 64'(ok), 64'(1));
    wait_sig(P_M0ERR, 12, w, ok);
    chk("D_m0_err_latency", 64'(w), 64'(8));
    chk("D_s_cyc_forced_low", 64'(s_cyc), 64'(0));
    tick();
    chk("D_m0_err_one_pulse", 64'(m0_err), 64'(0));
    chk("D_grant_idle", 64'(grant), 64'(2'b00));
    tick();
    chk("D_grant_m1_next", 64'(grant), 64'(2'b10));
    wait_sig(P_M1ERR, 12, w, ok);
    chk("D_m1_err_latency", 64'(w), 64'(8));
    repeat (3) tick();

    // m0 aborts 2 cycles into its transfer while m1 waits
    slave_dly = 4;
    issued[0] = issued[0] + 1;
    issued[1] = issued[1] + 1;
    wait_sig(P_G01, 6, w, ok);
    chk("E_grant_m0", 64'(ok), 64'(1));
    bad = 1'b0;
    tick();
    bad |= m0_ack | m0_err;
    m_drop[0] = 1'b1;
    tick();
    bad |= m0_ack | m0_err;
    chk("E_s_cyc_dropped", 64'(s_cyc), 64'(0));
    tick();
    bad |= m0_ack | m0_err;
    chk("E_grant_idle", 64'(grant), 64'(2'b00));
    tick();
    chk("E_grant_m1", 64'(grant), 64'(2'b10));
    for (int i = 0; i < 8; i++) begin
      tick();
      bad |= m0_ack | m0_err;
    end
    chk("E_m0_no_response", 64'(bad), 64'(0));
    wait_sig(P_IDLE, 6, w, ok);
    repeat (2) tick();

    // reset during BUS1, stray ack after release
    slave_dly = 0;
    issued[1] = issued[1] + 1;
    wait_sig(P_G10, 6, w, ok);
    chk("F_grant_m1", 64'(ok), 64'(1));
    bad = 1'b0;
    tick();
    reset = 1'b1;
    bad |= m0_ack | m1_ack | m1_err;
    tick();
    reset = 1'b0;
    bad |= m0_ack | m1_ack | m1_err;
    tick();
    force_ack = 1'b1;
    bad |= m0_ack | m1_ack | m1_err;
    tick();
    force_ack = 1'b0;
    bad |= m0_ack | m1_ack | m1_err;
    chk("F_grant_idle_on_ack", 64'(grant), 64'(2'b00));
    for (int i = 0; i < 4; i++) begin
      tick();
      bad |= m0_ack | m1_ack | m1_err;
    end
    chk("F_no_response", 64'(bad), 64'(0));
    chk("F_grant_idle_end", 64'(grant), 64'(2'b00));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
